// File: rtl/ysyx_220066_div_issue_if.sv
// ysyx_220066_div_issue_if: issue-side handshake bundle between execute stage, divider and writeback
// slave  : the issue block (takes req_*, res_ready, div_in_ready, div_out_valid, div_result)
// master : the environment driving it (execute stage, divider, writeback)
interface ysyx_220066_div_issue_if;
  logic        req_valid;
  logic        req_ready;
  logic [63:0] req_src1;
  logic [63:0] req_src2;
  logic        req_is_w;
  logic [1:0]  req_ALUctr;
  logic        flush;
  logic        res_valid;
  logic        res_ready;
  logic [63:0] res_data;
  logic        div_in_valid;
  logic        div_in_ready;
  logic [63:0] div_src1;
  logic [63:0] div_src2;
  logic        div_is_w;
  logic [1:0]  div_ALUctr;
  logic        div_out_valid;
  logic [63:0] div_result;
  modport slave (
    input  req_valid, req_src1, req_src2, req_is_w, req_ALUctr, flush, res_ready,
           div_in_ready, div_out_valid, div_result,
    output req_ready, res_valid, res_data, div_in_valid, div_src1, div_src2, div_is_w, div_ALUctr
  );
  modport master (
    output req_valid, req_src1, req_src2, req_is_w, req_ALUctr, flush, res_ready,
           div_in_ready, div_out_valid, div_result,
    input  req_ready, res_valid, res_data, div_in_valid, div_src1, div_src2, div_is_w, div_ALUctr
  );
endinterface

// File: rtl/ysyx_220066_div_issue.sv
// ysyx_220066_div_issue: issues div/rem ops to a variable-latency divider and holds the result for writeback
// ports: clk, rst_n (async active-low), bus (ysyx_220066_div_issue_if.slave)
// optional: YSYX_220066_DIV_ZERO_BYPASS_EN answers divide-by-zero locally without using the divider
module ysyx_220066_div_issue (
  input logic clk,
  input logic rst_n,
  ysyx_220066_div_issue_if.slave bus
);
  typedef enum logic [1:0] {IDLE, WAIT, DONE, DRAIN} state_t;
  state_t      state;
  logic        w_q;
  logic [63:0] res_q;
  logic        bypass;
  logic [63:0] byp_res;
  logic        go;
  logic [63:0] adj;
`ifdef YSYX_220066_DIV_ZERO_BYPASS_EN
  assign bypass  = bus.req_is_w ? (bus.req_src2[31:0] == 32'd0) : (bus.req_src2 == 64'd0);
  assign byp_res = bus.req_ALUctr[1] ?
                   (bus.req_is_w ? {{32{bus.req_src1[31]}}, bus.req_src1[31:0]} : bus.req_src1) : '1;
`else
  assign bypass  = 1'b0;
  assign byp_res = '0;
`endif
  assign bus.div_src1   = bus.req_src1;
  assign bus.div_src2   = bus.req_src2;
  assign bus.div_is_w   = bus.req_is_w;
  assign bus.div_ALUctr = bus.req_ALUctr;
  // rst_n gates the handshake so nothing is offered or accepted while held in reset
  assign go               = rst_n & (state == IDLE) & bus.req_valid & ~bus.flush;
  assign bus.div_in_valid = go & ~bypass;
  assign bus.req_ready    = go & (bypass | bus.div_in_ready);
  assign bus.res_valid    = (state == DONE);
  assign bus.res_data     = res_q;
  // W flag is latched at acceptance since the execute stage may move on while we wait
  assign adj = w_q ? {{32{bus.div_result[31]}}, bus.div_result[31:0]} : bus.div_result;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      w_q   <= 1'b0;
      res_q <= '0;
    end else begin
      case (state)
        IDLE: if (bus.req_ready) begin
          w_q   <= bus.req_is_w;
          state <= bypass ? DONE : WAIT;
          if (bypass) res_q <= byp_res;
        end
        WAIT: if (bus.flush) state <= bus.div_out_valid ? IDLE : DRAIN;
              else if (bus.div_out_valid) begin
                res_q <= adj;
                state <= DONE;
              end
        DONE: if (bus.flush || bus.res_ready) state <= IDLE;
        DRAIN: if (bus.div_out_valid) state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ysyx_220066_div_issue.sv
// tb_ysyx_220066_div_issue: directed and random checks of the div issue block against a RISC-V div/rem model
module tb_ysyx_220066_div_issue;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int total = 0;
  int bad = 0;
  ysyx_220066_div_issue_if bus();
  ysyx_220066_div_issue dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;

  function automatic logic [63:0] ref_res(input logic [63:0] s1, input logic [63:0] s2,
                                          input logic w, input logic [1:0] ctr);
    logic [31:0] a, b, r;
    logic [63:0] z;
    a = s1[31:0];
    b = s2[31:0];
    if (w) begin
      if (b == 32'd0) r = ctr[1] ? a : '1;
      else if (!ctr[0] && a == 32'h8000_0000 && b == '1) r = ctr[1] ? 32'd0 : a;
      else if (ctr[0]) r = ctr[1] ? a % b : a / b;
      else r = ctr[1] ? 32'($signed(a) % $signed(b)) : 32'($signed(a) / $signed(b));
      return {{32{r[31]}}, r};
    end
    if (s2 == 64'd0) z = ctr[1] ? s1 : '1;
    else if (!ctr[0] && s1 == 64'h8000_0000_0000_0000 && s2 == '1) z = ctr[1] ? 64'd0 : s1;
    else if (ctr[0]) z = ctr[1] ? s1 % s2 : s1 / s2;
    else z = ctr[1] ? 64'($signed(s1) % $signed(s2)) : 64'($signed(s1) / $signed(s2));
    return z;
  endfunction

  function automatic logic byp(input logic [63:0] s2, input logic w);
`ifdef YSYX_220066_DIV_ZERO_BYPASS_EN
    return w ? (s2[31:0] == 32'd0) : (s2 == 64'd0);
`else
    return 1'b0;
`endif
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic present(input logic [63:0] s1, input logic [63:0] s2, input logic w, input logic [1:0] ctr);
    bus.req_src1   = s1;
    bus.req_src2   = s2;
    bus.req_is_w   = w;
    bus.req_ALUctr = ctr;
    bus.req_valid  = 1'b1;
  endtask

  task automatic run_op(input logic [63:0] s1, input logic [63:0] s2, input logic w, input logic [1:0] ctr,
                        input logic [63:0] e, input int lat, input int hold);
    present(s1, s2, w, ctr);
    #1;
    chk("div_src1", bus.div_src1, s1);
    chk("div_src2", bus.div_src2, s2);
    chk("div_ctl", 64'({bus.div_is_w, bus.div_ALUctr}), 64'({w, ctr}));
    if (byp(s2, w)) begin
      bus.div_in_ready = 1'b0;
      #1;
      chk("byp_div_in_valid", 64'(bus.div_in_valid), 64'd0);
      chk("byp_req_ready", 64'(bus.req_ready), 64'd1);
      tick;
    end else begin
      chk("div_in_valid", 64'(bus.div_in_valid), 64'd1);
      chk("req_ready", 64'(bus.req_ready), 64'd1);
      tick;
      bus.req_valid = 1'b0;
      bus.div_in_ready = 1'b0;
      repeat (lat - 1) begin
        #1;
        chk("busy_div_in_valid", 64'(bus.div_in_valid), 64'd0);
        chk("busy_res_valid", 64'(bus.res_valid), 64'd0);
        tick;
      end
      bus.div_out_valid = 1'b1;
      bus.div_result = w ? {$urandom, e[31:0]} : e;
      tick;
      bus.div_out_valid = 1'b0;
    end
    bus.div_in_ready = 1'b1;
    bus.req_valid = 1'b1;
    repeat (hold) begin
      #1;
      chk("hold_res_valid", 64'(bus.res_valid), 64'd1);
      chk("hold_res_data", bus.res_data, e);
      chk("hold_req_ready", 64'(bus.req_ready), 64'd0);
      chk("hold_div_in_valid", 64'(bus.div_in_valid), 64'd0);
      tick;
    end
    bus.res_ready = 1'b1;
    #1;
    chk("res_valid", 64'(bus.res_valid), 64'd1);
    chk("res_data", bus.res_data, e);
    chk("consume_req_ready", 64'(bus.req_ready), 64'd0);
    tick;
    bus.res_ready = 1'b0;
    bus.req_valid = 1'b0;
    #1;
    chk("after_res_valid", 64'(bus.res_valid), 64'd0);
  endtask

  initial begin
    logic [63:0] s1, s2;
    logic w;
    logic [1:0] ctr;
    bus.req_valid = 1'b1;
    bus.req_src1 = 64'd5;
    bus.req_src2 = 64'd1;
    bus.req_is_w = 1'b0;
    bus.req_ALUctr = 2'b00;
    bus.flush = 1'b0;
    bus.res_ready = 1'b0;
    bus.div_in_ready = 1'b1;
    bus.div_out_valid = 1'b0;
    bus.div_result = 64'd0;
    repeat (2) tick;
    #1;
    chk("rst_req_ready", 64'(bus.req_ready), 64'd0);
    chk("rst_div_in_valid", 64'(bus.div_in_valid), 64'd0);
    chk("rst_res_valid", 64'(bus.res_valid), 64'd0);
    chk("rst_res_data", bus.res_data, 64'd0);
    bus.req_valid = 1'b0;
    tick;
    rst_n = 1'b1;
    tick;
    run_op(-64'sd20, 64'd3, 1'b0, 2'b00, 64'hFFFF_FFFF_FFFF_FFFA, 5, 5);
    run_op(64'h0000_0000_FFFF_FFF9, 64'h10, 1'b1, 2'b11, 64'd9, 3, 1);
    run_op(64'h0000_0000_FFFF_FFFE, 64'd1, 1'b1, 2'b01, 64'hFFFF_FFFF_FFFF_FFFE, 1, 0);
    // flush ten cycles after acceptance, then a flush in DRAIN that must be ignored
    present(64'd100, 64'd7, 1'b0, 2'b00);
    tick;
    bus.req_valid = 1'b0;
    bus.div_in_ready = 1'b0;
    repeat (9) tick;
    bus.flush = 1'b1;
    #1;
    chk("wait_flush_div_in_valid", 64'(bus.div_in_valid), 64'd0);
    tick;
    bus.req_valid = 1'b1;
    bus.div_in_ready = 1'b1;
    #1;
    chk("drain_div_in_valid", 64'(bus.div_in_valid), 64'd0);
    chk("drain_req_ready", 64'(bus.req_ready), 64'd0);
    chk("drain_res_valid", 64'(bus.res_valid), 64'd0);
    tick;
    bus.flush = 1'b0;
    #1;
    chk("drain_flush_ignored", 64'(bus.div_in_valid), 64'd0);
    bus.div_out_valid = 1'b1;
    bus.div_result = 64'd14;
    tick;
    bus.div_out_valid = 1'b0;
    #1;
    chk("drain_done_res_valid", 64'(bus.res_valid), 64'd0);
    chk("drain_done_idle", 64'(bus.div_in_valid), 64'd1);
    bus.req_valid = 1'b0;
    run_op(64'd100, 64'd7, 1'b0, 2'b10, 64'd2, 2, 0);
    // flush together with the divider pulse drops the result
    present(64'd50, 64'd5, 1'b0, 2'b00);
    tick;
    bus.req_valid = 1'b0;
    bus.div_in_ready = 1'b0;
    repeat (2) tick;
    bus.div_out_valid = 1'b1;
    bus.div_result = 64'd10;
    bus.flush = 1'b1;
    tick;
    bus.div_out_valid = 1'b0;
    bus.flush = 1'b0;
    bus.req_valid = 1'b1;
    bus.div_in_ready = 1'b1;
    #1;
    chk("flushpulse_res_valid", 64'(bus.res_valid), 64'd0);
    chk("flushpulse_idle", 64'(bus.div_in_valid), 64'd1);
    bus.req_valid = 1'b0;
    // flush in IDLE blocks acceptance
    present(64'd9, 64'd2, 1'b0, 2'b00);
    bus.flush = 1'b1;
    #1;
    chk("idle_flush_div_in_valid", 64'(bus.div_in_valid), 64'd0);
    chk("idle_flush_req_ready", 64'(bus.req_ready), 64'd0);
    tick;
    bus.flush = 1'b0;
    #1;
    chk("idle_flush_still_idle", 64'(bus.div_in_valid), 64'd1);
    // flush in DONE retires without writeback
    tick;
    bus.req_valid = 1'b0;
    bus.div_in_ready = 1'b0;
    bus.div_out_valid = 1'b1;
    bus.div_result = 64'd4;
    tick;
    bus.div_out_valid = 1'b0;
    #1;
    chk("done_res_valid", 64'(bus.res_valid), 64'd1);
    chk("done_res_data", bus.res_data, 64'd4);
    bus.flush = 1'b1;
    tick;
    bus.flush = 1'b0;
    #1;
    chk("done_flush_res_valid", 64'(bus.res_valid), 64'd0);
    // reset pulse in WAIT clears outputs immediately and ignores the late pulse
    bus.div_in_ready = 1'b1;
    present(64'd77, 64'd3, 1'b0, 2'b00);
    tick;
    bus.div_in_ready = 1'b0;
    tick;
    bus.div_in_ready = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    chk("wrst_req_ready", 64'(bus.req_ready), 64'd0);
    chk("wrst_div_in_valid", 64'(bus.div_in_valid), 64'd0);
    chk("wrst_res_valid", 64'(bus.res_valid), 64'd0);
    chk("wrst_res_data", bus.res_data, 64'd0);
    bus.req_valid = 1'b0;
    tick;
    rst_n = 1'b1;
    bus.div_out_valid = 1'b1;
    bus.div_result = 64'd25;
    tick;
    bus.div_out_valid = 1'b0;
    #1;
    chk("wrst_late_res_valid", 64'(bus.res_valid), 64'd0);
`ifdef YSYX_220066_DIV_ZERO_BYPASS_EN
    run_op(-64'sd7, 64'd0, 1'b0, 2'b00, 64'hFFFF_FFFF_FFFF_FFFF, 1, 1);
    run_op(64'h0000_0000_8000_0005, 64'd0, 1'b1, 2'b10, 64'hFFFF_FFFF_8000_0005, 1, 0);
`endif
    for (int i = 0; i < 40; i++) begin
      s1 = {$urandom, $urandom};
      case ($urandom_range(0, 4))
        0: s2 = 64'd0;
        1: s2 = 64'($urandom_range(1, 20));
        2: s2 = '1;
        default: s2 = {$urandom, $urandom};
      endcase
      if ($urandom_range(0, 7) == 0) s1 = 64'h8000_0000_0000_0000;
      if ($urandom_range(0, 7) == 0) s1 = 64'hFFFF_FFFF_8000_0000;
      w = 1'($urandom);
      ctr = 2'($urandom);
      run_op(s1, s2, w, ctr, ref_res(s1, s2, w, ctr), int'($urandom_range(1, 8)), int'($urandom_range(0, 3)));
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/ysyx_220066_div_issue.md
YSYX_220066_DIV_ISSUE -- requirements
Module: ysyx_220066_div_issue

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-002 Ports SHALL be as listed:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  execute stage presents a div/rem op
- req_ready  out  1  op accepted this cycle
- req_src1, req_src2  in  64  dividend, divisor
- req_is_w  in  1  32-bit (W) op
- req_ALUctr  in  2  bit0=1 unsigned, bit1=1 remainder
- flush  in  1  kill current op
- res_valid  out  1  result held for writeback
- res_ready  in  1  writeback consumes result
- res_data  out  64  final result
- div_in_valid  out  1  start request to divider
- div_in_ready  in  1  divider idle / accepting
- div_src1, div_src2  out  64  operands to divider
- div_is_w  out  1  W flag to divider
- div_ALUctr  out  2  op code to divider
- div_out_valid  in  1  single-cycle divider completion pulse
- div_result  in  64  divider result, sampled only when div_out_valid=1

Function
REQ-003 The FSM SHALL have four states: IDLE, WAIT, DONE, DRAIN.
REQ-004 div_src1, div_src2, div_is_w and div_ALUctr SHALL be driven combinationally from the req_* inputs.
REQ-005 div_in_valid SHALL equal (IDLE & req_valid & ~flush & ~bypass), where bypass is defined in REQ-013.
REQ-006 req_ready SHALL equal (div_in_valid & div_in_ready), or the bypass acceptance of REQ-013; on acceptance the FSM SHALL move IDLE->WAIT.
REQ-007 In WAIT, div_out_valid SHALL capture the adjusted result into the result register and move the FSM to DONE.
REQ-008 Result adjustment: a W op SHALL yield {32{div_result[31]}, div_result[31:0]}; a non-W op SHALL pass div_result unchanged.
REQ-009 In DONE, res_valid=1 and res_data SHALL hold the result register stably; res_ready=1 SHALL move the FSM to IDLE, with no new acceptance in that same cycle.
REQ-010 Flush behaviour:
- flush in WAIT SHALL move the FSM to DRAIN.
- flush in DONE SHALL move the FSM to IDLE without asserting res_valid again.
- flush in IDLE SHALL block acceptance that cycle.
- flush in DRAIN SHALL be ignored.
REQ-011 In DRAIN, div_out_valid SHALL be discarded and the FSM SHALL move to IDLE; flush and div_out_valid together in WAIT SHALL discard the result and move the FSM to IDLE.
REQ-012 The block SHALL NOT depend on a fixed divider latency, and SHALL NOT assert div_in_valid outside IDLE.

Reset
REQ-014 While rst_n=0, the FSM SHALL be IDLE and req_ready, res_valid and div_in_valid SHALL be 0.
REQ-015 While rst_n=0, res_data SHALL be 0.
REQ-016 Reset SHALL act asynchronously; deassertion SHALL be synchronized externally.
REQ-017 Reset asserted during WAIT SHALL abandon the op, with no result output after reset.

Configuration
REQ-013 Macro YSYX_220066_DIV_ZERO_BYPASS_EN:
- When defined and the divisor is zero, bypass=1. The divisor is zero when req_src2==0, or req_src2[31:0]==0 for a W op.
- A bypassed op is accepted in IDLE whenever ~flush, regardless of div_in_ready, and the FSM moves directly to DONE.
- Bypassed quotient SHALL be all ones (64'hFFFF_FFFF_FFFF_FFFF).
- Bypassed remainder SHALL be req_src1 (non-W) or sign-extended req_src1[31:0] (W).
- When the macro is undefined, bypass=0 and divide-by-zero goes to the divider like any other op.

Verification
REQ-018 Directed scenarios the bench SHALL cover:
- DIV src1=-20, src2=3, non-W -> one div_in_valid pulse, then res_valid with res_data=-6 held until res_ready.
- REMUW src1=0x0000_0000_FFFF_FFF9, src2=0x10 -> res_data=0x0000_0000_0000_0009; DIVUW src1=0xFFFF_FFFE, src2=1 -> res_data=0xFFFF_FFFF_FFFF_FFFE (sign-extended).
- Flush 10 cycles after acceptance -> FSM in DRAIN, divider pulse discarded, res_valid never 1, next op accepted after drain.
- Flush in the same cycle as div_out_valid -> no res_valid; rst_n pulse during WAIT -> all outputs 0 immediately.
- Macro defined: DIV -7/0 -> DONE next cycle, res_data=all ones, div_in_valid stays 0; REMW 0x8000_0005/0 -> 0xFFFF_FFFF_8000_0005.
- res_ready held 0 for 5 cycles in DONE -> res_data stable, req_ready=0 throughout.
